// File: rtl/mix_columns_iter_if.sv
// Handshake bundle for mix_columns_iter: one 128-bit state in, one transformed state out.
interface mix_columns_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport master (
    output in_valid, in_state, in_inv, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, in_inv, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns/InvMixColumns engine: COLS_PER_CYCLE columns per clock,
// result held in a one-block output register until the consumer takes it.
module mix_columns_iter #(
  parameter int unsigned COLS_PER_CYCLE = 1,
  parameter bit          ENABLE_INV     = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  mix_columns_iter_if.slave bus
);

  localparam int unsigned NCYC = 4 / COLS_PER_CYCLE;

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e       state_q, state_d;
  logic [127:0] buf_q, buf_d;
  logic [127:0] out_q, out_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         mode_q, mode_d;
  logic         in_ready_c;
  logic         capture;
  logic         last_grp;
  logic         inv_en;
  logic [127:0] grp_buf;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    for (int r = 0; r < 4; r++) begin
      if (inv) begin
        // 0E, 0B, 0D, 09 built from the x8/x4/x2 chain
        res[31-8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r])
                         ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                         ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                         ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
      end else begin
        res[31-8*r -: 8] = x2[r] ^ (x2[(r+1)%4] ^ a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
      end
    end
    return res;
  endfunction

  // Constant-folds the inverse half away when ENABLE_INV is 0.
  assign inv_en   = ENABLE_INV && mode_q;
  assign last_grp = (cnt_q == 2'(NCYC - 1));

  always_comb begin
    grp_buf = buf_q;
    for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
      grp_buf[127 - 32*(int'(cnt_q)*COLS_PER_CYCLE + g) -: 32] =
        mix_col(buf_q[127 - 32*(int'(cnt_q)*COLS_PER_CYCLE + g) -: 32], inv_en);
    end
  end

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    out_d      = out_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    in_ready_c = 1'b0;
    capture    = 1'b0;

    case (state_q)
      StIdle: begin
        in_ready_c = 1'b1;
        capture    = bus.in_valid;
      end
      StBusy: begin
        buf_d = grp_buf;
        cnt_d = cnt_q + 2'd1;
        if (last_grp) begin
          state_d = StDone;
          out_d   = grp_buf;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          in_ready_c = 1'b1;
          if (bus.in_valid) begin
            capture = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (capture) begin
      buf_d   = bus.in_state;
      mode_d  = ENABLE_INV ? bus.in_inv : 1'b0;
      cnt_d   = 2'd0;
      state_d = StBusy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      buf_q   <= '0;
      out_q   <= '0;
      cnt_q   <= 2'd0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_state = out_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Scoreboard bench for mix_columns_iter: main instance at 1 column/cycle plus
// 2- and 4-column and forward-only instances for latency and mode checks.
module tb_mix_columns_iter;

  localparam int NCYC = 4;
  localparam logic [127:0] FIPS_IN  = {4{32'hdb135345}};
  localparam logic [127:0] FIPS_OUT = {4{32'h8e4da1bc}};
  localparam logic [127:0] MIX_IN   = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] MIX_OUT  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] FIX      = 128'h01010101_c6c6c6c6_01010101_c6c6c6c6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mix_columns_iter_if bus ();
  mix_columns_iter_if bus2 ();
  mix_columns_iter_if bus4 ();
  mix_columns_iter_if busf ();

  mix_columns_iter #(.COLS_PER_CYCLE(1), .ENABLE_INV(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  mix_columns_iter #(.COLS_PER_CYCLE(2), .ENABLE_INV(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  mix_columns_iter #(.COLS_PER_CYCLE(4), .ENABLE_INV(1'b1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  mix_columns_iter #(.COLS_PER_CYCLE(1), .ENABLE_INV(1'b0)) u_dutf (
    .clk(clk), .rst_n(rst_n), .bus(busf.slave));

  // Shared stimulus for the side instances, which always accept output.
  logic         s_valid;
  logic [127:0] s_state;
  logic         s_inv;
  assign bus2.in_valid = s_valid;  assign bus2.in_state = s_state;  assign bus2.in_inv = s_inv;
  assign bus4.in_valid = s_valid;  assign bus4.in_state = s_state;  assign bus4.in_inv = s_inv;
  assign busf.in_valid = s_valid;  assign busf.in_state = s_state;  assign busf.in_inv = s_inv;
  assign bus2.out_ready = 1'b1;
  assign bus4.out_ready = 1'b1;
  assign busf.out_ready = 1'b1;

  bit   rand_rdy;
  logic rdy_rand;
  logic rdy_force;
  assign bus.out_ready = rand_rdy ? rdy_rand : rdy_force;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_n;
  logic [127:0] exp_q[$];
  int           hs_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    rdy_rand = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rdy_rand = ($urandom_range(0, 3) != 0);
    end
  end

  // GF(2^8) product by carry-less multiply then reduction modulo 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
    logic [7:0]   row [4];
    logic [7:0]   acc;
    logic [127:0] o;
    if (inv) row = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     row = '{8'h02, 8'h03, 8'h01, 8'h01};
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(row[(k - r + 4) % 4], s[127-8*(4*c+k) -: 8]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Output monitor: latency on each rising out_valid, data on each transfer, stability on stall.
  bit           prev_v;
  logic [127:0] held;
  initial begin
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (bus.out_valid && !prev_v) begin
          held = bus.out_state;
          if (hs_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL spurious_valid: out_valid rose at cycle %0d with no block pending", cyc);
          end else begin
            chk("latency", 128'(cyc), 128'(hs_q.pop_front() + NCYC));
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL extra_output: got %h expected nothing", bus.out_state);
          end else begin
            chk("data", bus.out_state, exp_q.pop_front());
          end
        end else if (bus.out_valid) begin
          chk("stall_state", bus.out_state, held);
          chk("stall_in_ready", 128'(bus.in_ready), 128'(0));
        end
        prev_v = bus.out_valid;
      end
    end
  end

  task automatic send(input logic [127:0] s, input logic inv, input logic [127:0] e);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_state = s;
    bus.in_inv   = inv;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    bus.in_state = {$urandom, $urandom, $urandom, $urandom};
    bus.in_inv   = 1'($urandom);
    last_n = n;
    if (!acc) begin
      n_vec++; n_bad++;
      $display("FAIL send_timeout: in_ready never high in %0d cycles", n);
    end else begin
      exp_q.push_back(e);
      hs_q.push_back(cyc);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL drain_timeout: %0d outputs still pending", exp_q.size());
      exp_q.delete();
      hs_q.delete();
    end
  endtask

  task automatic run_side(input logic [127:0] s, input logic inv, input logic [127:0] e2,
                          input logic [127:0] e4, input logic [127:0] ef);
    int g2, g4, gf;
    g2 = -1; g4 = -1; gf = -1;
    s_valid = 1'b1;
    s_state = s;
    s_inv   = inv;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_state = {$urandom, $urandom, $urandom, $urandom};
    s_inv   = 1'($urandom);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (bus2.out_valid && g2 < 0) begin g2 = k; chk("c2_data", bus2.out_state, e2); end
      if (bus4.out_valid && g4 < 0) begin g4 = k; chk("c4_data", bus4.out_state, e4); end
      if (busf.out_valid && gf < 0) begin gf = k; chk("noinv_data", busf.out_state, ef); end
    end
    chk("c2_latency", 128'(g2), 128'(2));
    chk("c4_latency", 128'(g4), 128'(1));
    chk("noinv_latency", 128'(gf), 128'(4));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] s;
    logic         inv;
    int           n;

    bus.in_valid = 1'b0;
    bus.in_state = '0;
    bus.in_inv   = 1'b0;
    rand_rdy     = 1'b0;
    rdy_force    = 1'b1;
    s_valid      = 1'b0;
    s_state      = '0;
    s_inv        = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_out_state", bus.out_state, 128'(0));
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(FIPS_IN, 1'b0, FIPS_OUT);
    drain();
    send(MIX_IN, 1'b0, MIX_OUT);
    send(MIX_OUT, 1'b1, MIX_IN);
    send(FIX, 1'b0, FIX);
    send(FIX, 1'b1, FIX);
    drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s   = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'($urandom_range(0, 1));
      send(s, inv, ref_mix(s, inv));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    rand_rdy = 1'b0;

    // Backpressure, then a new block accepted in the same cycle the result leaves.
    rdy_force = 1'b0;
    send(MIX_IN, 1'b0, MIX_OUT);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_valid_seen", 128'(bus.out_valid), 128'(1));
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    rdy_force = 1'b1;
    s = {$urandom, $urandom, $urandom, $urandom};
    send(s, 1'b1, ref_mix(s, 1'b1));
    chk("bp_accept_cycles", 128'(last_n), 128'(1));
    drain();

    // Reset while the second column is being processed.
    send(MIX_IN, 1'b0, MIX_OUT);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    hs_q.delete();
    chk("midrst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("midrst_out_state", bus.out_state, 128'(0));
    chk("midrst_in_ready", 128'(bus.in_ready), 128'(1));
    @(posedge clk);
    #1;
    send(FIPS_IN, 1'b0, FIPS_OUT);
    drain();

    run_side(FIPS_IN, 1'b0, FIPS_OUT, FIPS_OUT, FIPS_OUT);
    run_side(FIPS_IN, 1'b1, ref_mix(FIPS_IN, 1'b1), ref_mix(FIPS_IN, 1'b1), FIPS_OUT);
    run_side(MIX_OUT, 1'b1, MIX_IN, MIX_IN, ref_mix(MIX_OUT, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
